regfile_sweep: RTL and testbench
================================

// Module: regfile_sweep
// PURPOSE
//  Parametrised 2-read/1-write CPU register file, successor to the fixed 8x16 file.
//  Generalises width and depth, and keeps R0 hardwired to zero as an option.
//  Adds write-first bypass and a multi-cycle clear sweep with a busy flag.
//  Sits between decode (read addresses) and writeback (write port) of the datapath.
// PARAMETERS
//  WIDTH     16  data width of each register
//  DEPTH     8   number of registers, power of two, >=2
//  ADDR_W    3   address width, must equal log2(DEPTH)
//  ZERO_REG  1   1: register 0 reads 0 and ignores writes; 0: R0 is ordinary
//  BYPASS    1   1: same-cycle write forwarded to read; 0: read returns old value
// PORTS
//  clk       in   1       rising-edge clock
//  rst_n     in   1       asynchronous active-low reset
//  clear     in   1       pulse: start sweep that zeroes every register
//  busy      out  1       high while clear sweep in progress
//  write     in   1       write enable
//  inaddr    in   ADDR_W  write address
//  in        in   WIDTH   write data
//  addr1     in   ADDR_W  read port 1 address
//  addr2     in   ADDR_W  read port 2 address
//  out1      out  WIDTH   read port 1 data, registered
//  out2      out  WIDTH   read port 2 data, registered
//  wr_drop   out  1       1-cycle pulse: a write was discarded because busy
// BEHAVIOUR
//  Reset (rst_n=0, async): all registers, out1, out2 = 0; busy=0; wr_drop=0; FSM=IDLE; sweep ctr=0.
//  Reads: out1/out2 update at every rising edge with value at addr1/addr2, 1-cycle latency.
//  Write: at edge with write=1, vals[inaddr]<=in unless dropped (below).
//  ZERO_REG=1: writes to addr 0 ignored, no wr_drop; reads of addr 0 always return 0.
//  BYPASS=1: if write=1, accepted, and inaddr==addrN, outN<=in (write-first).
//  BYPASS=0: outN<=old stored value (read-before-write).
//  FSM IDLE -> SWEEP on edge with clear=1; ctr<=0; busy rises in the following cycle.
//  SWEEP: each edge zeroes vals[ctr], ctr++; after ctr==DEPTH-1 cleared -> IDLE.
//  Sweep length is exactly DEPTH cycles; busy is high for DEPTH cycles.
//  While busy: out1/out2 <= 0 regardless of address; writes discarded, wr_drop=1 next cycle.
//  Write in the same cycle as clear (IDLE): write is accepted first, then swept to 0.
//  clear while busy: ignored (sweep not restarted, not extended).
//  First edge after busy falls: normal reads/writes; all registers read 0.
//  rst_n asserted mid-sweep: immediate return to IDLE with all registers 0.
//  ctr width ADDR_W; wraps only at sweep end, never exposed.
// TESTING
//  Reset, then read all addrs -> out1=out2=0; busy=0; wr_drop=0.
//  Write R3=0xBEEF, next cycle addr1=3 -> out1=0xBEEF one edge later.
//  Write R5=0x1234 with addr1=5 same cycle -> out1=0x1234 (BYPASS=1); old value (BYPASS=0).
//  Write R0=0xFFFF, read addr1=0 -> out1=0, wr_drop=0 (ZERO_REG=1); 0xFFFF if ZERO_REG=0.
//  Fill R1..R7, pulse clear -> busy high 8 cycles; write mid-sweep -> wr_drop pulse; then all read 0.
//  Pulse clear, drop rst_n on cycle 3 of sweep -> busy=0 immediately; all regs 0; new write works.

Source files
------------

// File: rtl/regfile_sweep_if.sv
// Register-file port bundle: write port, two read ports and the clear/busy sweep control.
// The master drives addresses/data and the slave returns registered read data and status.
interface regfile_sweep_if #(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned ADDR_W = 3
);
   logic              clear;
   logic              busy;
   logic              write;
   logic [ADDR_W-1:0] inaddr;
   logic [WIDTH-1:0]  in;
   logic [ADDR_W-1:0] addr1;
   logic [ADDR_W-1:0] addr2;
   logic [WIDTH-1:0]  out1;
   logic [WIDTH-1:0]  out2;
   logic              wr_drop;

   modport master (
      output clear, write, inaddr, in, addr1, addr2,
      input  busy, out1, out2, wr_drop
   );

   modport slave (
      input  clear, write, inaddr, in, addr1, addr2,
      output busy, out1, out2, wr_drop
   );
endinterface

// File: rtl/regfile_sweep.sv
// Parametrised 2-read/1-write register file with optional hardwired R0, write-first bypass
// and a DEPTH-cycle clear sweep during which reads return 0 and writes are dropped.
module regfile_sweep #(
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned DEPTH    = 8,
   parameter int unsigned ADDR_W   = 3,
   parameter bit          ZERO_REG = 1'b1,
   parameter bit          BYPASS   = 1'b1
) (
   input logic           clk,
   input logic           rst_n,
   regfile_sweep_if.slave bus
);

   typedef enum logic {StIdle, StSweep} state_e;

   state_e            state_q;
   logic [ADDR_W-1:0] ctr_q;
   logic [WIDTH-1:0]  vals_q [DEPTH];
   logic [WIDTH-1:0]  out1_q, out2_q;
   logic [WIDTH-1:0]  rd1_d, rd2_d;
   logic              busy_q, drop_q;
   logic              wr_zero, wr_accept;

   // Writes to a hardwired R0 are silently ignored and never count as dropped.
   assign wr_zero   = ZERO_REG && (bus.inaddr == '0);
   assign wr_accept = bus.write && (state_q == StIdle) && !wr_zero;

   function automatic logic [WIDTH-1:0] rd_port(input logic [ADDR_W-1:0] a);
      logic [WIDTH-1:0] v;
      v = vals_q[a];
      if (state_q == StSweep) begin
         v = '0;
      end else if (ZERO_REG && (a == '0)) begin
         v = '0;
      end else if (BYPASS && wr_accept && (bus.inaddr == a)) begin
         v = bus.in;
      end
      return v;
   endfunction

   always_comb begin
      rd1_d = rd_port(bus.addr1);
      rd2_d = rd_port(bus.addr2);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         ctr_q   <= '0;
         busy_q  <= 1'b0;
         drop_q  <= 1'b0;
         out1_q  <= '0;
         out2_q  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            vals_q[i] <= '0;
         end
      end else begin
         out1_q <= rd1_d;
         out2_q <= rd2_d;
         drop_q <= bus.write && (state_q == StSweep) && !wr_zero;
         if (wr_accept) begin
            vals_q[bus.inaddr] <= bus.in;
         end
         unique case (state_q)
            StIdle: begin
               if (bus.clear) begin
                  state_q <= StSweep;
                  busy_q  <= 1'b1;
                  ctr_q   <= '0;
               end
            end
            StSweep: begin
               vals_q[ctr_q] <= '0;
               ctr_q         <= ctr_q + ADDR_W'(1);
               if (ctr_q == ADDR_W'(DEPTH - 1)) begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
               end
            end
         endcase
      end
   end

   assign bus.out1    = out1_q;
   assign bus.out2    = out2_q;
   assign bus.busy    = busy_q;
   assign bus.wr_drop = drop_q;

endmodule

// File: tb/tb_regfile_sweep.sv
// Scoreboard bench for regfile_sweep: directed scenarios then random traffic, checked against
// a behavioural model of the register contents and the remaining busy cycles.
module tb_regfile_sweep;
   localparam int unsigned WIDTH  = 16;
   localparam int unsigned DEPTH  = 8;
   localparam int unsigned ADDR_W = 3;

   typedef struct packed {
      logic [WIDTH-1:0] o1;
      logic [WIDTH-1:0] o2;
      logic             busy;
      logic             drop;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   regfile_sweep_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

   regfile_sweep #(
      .WIDTH   (WIDTH),
      .DEPTH   (DEPTH),
      .ADDR_W  (ADDR_W),
      .ZERO_REG(1'b1),
      .BYPASS  (1'b1)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   exp_t             exp_q[$];
   int               n_cmp  = 0;
   int               n_fail = 0;
   logic [WIDTH-1:0] mem [DEPTH];
   int               left = 0;

   function automatic void chk(input string name, input logic [WIDTH-1:0] act,
                               input logic [WIDTH-1:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, req);
      end
   endfunction

   function automatic logic [WIDTH-1:0] model_rd(input logic [ADDR_W-1:0] a, input logic wr,
                                                input logic [ADDR_W-1:0] ia,
                                                input logic [WIDTH-1:0] d);
      if (left > 0 || a == 0) return '0;
      if (wr && ia == a) return d;
      return mem[a];
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < int'(DEPTH); i++) mem[i] = '0;
      left = 0;
   endfunction

   // One clock cycle: drive inputs, predict the post-edge outputs, update the model.
   task automatic step(input logic clr, input logic wr, input logic [ADDR_W-1:0] ia,
                       input logic [WIDTH-1:0] d, input logic [ADDR_W-1:0] a1,
                       input logic [ADDR_W-1:0] a2);
      exp_t e;
      @(negedge clk);
      bus.clear = clr; bus.write = wr; bus.inaddr = ia; bus.in = d;
      bus.addr1 = a1;  bus.addr2 = a2;
      e.o1   = model_rd(a1, wr, ia, d);
      e.o2   = model_rd(a2, wr, ia, d);
      e.drop = (left > 0) && wr && (ia != 0);
      if (left > 0) begin
         left--;
      end else begin
         if (wr && ia != 0) mem[ia] = d;
         // Registers are unreadable during the sweep, so zeroing them all now is equivalent.
         if (clr) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] = '0;
            left = DEPTH;
         end
      end
      e.busy = (left > 0);
      exp_q.push_back(e);
   endtask

   task automatic do_reset();
      @(negedge clk);
      bus.clear = 1'b0; bus.write = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("async_rst_busy", WIDTH'(bus.busy), '0);
      chk("async_rst_drop", WIDTH'(bus.wr_drop), '0);
      chk("async_rst_out1", bus.out1, '0);
      chk("async_rst_out2", bus.out2, '0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Monitor: outputs are valid every cycle, so each expectation is consumed at the next edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("out1", bus.out1, e.o1);
            chk("out2", bus.out2, e.o2);
            chk("busy", WIDTH'(bus.busy), WIDTH'(e.busy));
            chk("wr_drop", WIDTH'(bus.wr_drop), WIDTH'(e.drop));
         end
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.clear = 1'b0; bus.write = 1'b0; bus.inaddr = '0; bus.in = '0;
      bus.addr1 = '0;   bus.addr2 = '0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("reset_out1", bus.out1, '0);
      chk("reset_out2", bus.out2, '0);
      chk("reset_busy", WIDTH'(bus.busy), '0);
      chk("reset_drop", WIDTH'(bus.wr_drop), '0);
      rst_n = 1'b1;

      for (int i = 0; i < int'(DEPTH); i++) step(0, 0, 0, 0, ADDR_W'(i), ADDR_W'(DEPTH - 1 - i));

      step(0, 1, 3, 16'hBEEF, 0, 0);
      step(0, 0, 0, 0, 3, 1);
      step(0, 0, 0, 0, 0, 3);
      step(0, 1, 5, 16'h1234, 5, 5);
      step(0, 1, 0, 16'hFFFF, 0, 0);
      step(0, 0, 0, 0, 0, 5);

      for (int i = 1; i < int'(DEPTH); i++) step(0, 1, ADDR_W'(i), WIDTH'(16'hA000 + i), 0, 0);
      step(1, 1, 2, 16'h5555, 2, 7);
      for (int i = 0; i < int'(DEPTH); i++) begin
         step(i == 4, i == 2 || i == 5, ADDR_W'(i), 16'hDEAD, ADDR_W'(i), 3);
      end
      for (int i = 0; i < int'(DEPTH); i++) step(0, 0, 0, 0, ADDR_W'(i), ADDR_W'(DEPTH - 1 - i));

      for (int i = 1; i < int'(DEPTH); i++) step(0, 1, ADDR_W'(i), WIDTH'(16'hC000 + i), 0, 0);
      step(1, 0, 0, 0, 1, 2);
      repeat (3) step(0, 0, 0, 0, 4, 6);
      do_reset();
      step(0, 1, 2, 16'h7777, 2, 4);
      for (int i = 0; i < int'(DEPTH); i++) step(0, 0, 0, 0, ADDR_W'(i), 2);

      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 99) == 0) begin
            do_reset();
         end else begin
            step($urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1,
                 ADDR_W'($urandom), WIDTH'($urandom), ADDR_W'($urandom), ADDR_W'($urandom));
         end
      end

      @(negedge clk);
      bus.write = 1'b0; bus.clear = 1'b0;
      repeat (2) @(negedge clk);
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
